// File: rtl/deadtime_inserter_3phase_if.sv
// rtl/deadtime_inserter_3phase_if.sv - PWM command and gate-drive bundle for the 3-phase dead-time inserter
interface deadtime_inserter_3phase_if;
  logic       pwm_a;
  logic       pwm_b;
  logic       pwm_c;
  logic       a_hi;
  logic       a_lo;
  logic       b_hi;
  logic       b_lo;
  logic       c_hi;
  logic       c_lo;
  logic [2:0] dt_active;

  modport master (
    output pwm_a, pwm_b, pwm_c,
    input  a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, dt_active
  );

  modport slave (
    input  pwm_a, pwm_b, pwm_c,
    output a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, dt_active
  );
endinterface

// File: rtl/deadtime_inserter_3phase.sv
// rtl/deadtime_inserter_3phase.sv - complementary gate drives with programmable dead time and latched fault shutdown
module deadtime_inserter_3phase #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault,
  input  logic                fault_clear,
  output logic                fault_latched,
  deadtime_inserter_3phase_if.slave gate
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    DT_TO_HI = 3'd1,
    HI_ON    = 3'd2,
    DT_TO_LO = 3'd3,
    LO_ON    = 3'd4
  } state_t;

  state_t              state_q [3];
  state_t              state_d [3];
  logic [DT_WIDTH-1:0] cnt_q   [3];
  logic [DT_WIDTH-1:0] cnt_d   [3];
  logic [2:0]          ret_q, ret_d;
  logic [2:0]          pwm_q, pwm_in;
  logic [2:0]          hi_q, lo_q, dt_q;
  logic [2:0]          hi_d, lo_d, dt_d;
  logic [DT_WIDTH-1:0] dt_load;
  logic                gate_ok;

  assign pwm_in  = {gate.pwm_c, gate.pwm_b, gate.pwm_a};
  assign dt_load = (dead_time == '0) ? '0 : dead_time - 1'b1;
  assign gate_ok = enable & ~fault & ~fault_latched;

  // ret marks a dead time entered from an on state: only then may a
  // reversed command snap straight back to the side that was just on.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ret_d[i]   = ret_q[i];
      if (!gate_ok) begin
        state_d[i] = OFF;
        cnt_d[i]   = '0;
        ret_d[i]   = 1'b0;
      end else begin
        case (state_q[i])
          OFF: begin
            state_d[i] = pwm_q[i] ? DT_TO_HI : DT_TO_LO;
            cnt_d[i]   = dt_load;
            ret_d[i]   = 1'b0;
          end
          HI_ON: if (!pwm_q[i]) begin
            state_d[i] = DT_TO_LO;
            cnt_d[i]   = dt_load;
            ret_d[i]   = 1'b1;
          end
          LO_ON: if (pwm_q[i]) begin
            state_d[i] = DT_TO_HI;
            cnt_d[i]   = dt_load;
            ret_d[i]   = 1'b1;
          end
          DT_TO_HI: begin
            if (!pwm_q[i]) begin
              state_d[i] = ret_q[i] ? LO_ON : DT_TO_LO;
              cnt_d[i]   = dt_load;
              ret_d[i]   = 1'b0;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = HI_ON;
              ret_d[i]   = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
          DT_TO_LO: begin
            if (pwm_q[i]) begin
              state_d[i] = ret_q[i] ? HI_ON : DT_TO_HI;
              cnt_d[i]   = dt_load;
              ret_d[i]   = 1'b0;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = LO_ON;
              ret_d[i]   = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
          default: state_d[i] = OFF;
        endcase
      end
      hi_d[i] = (state_d[i] == HI_ON);
      lo_d[i] = (state_d[i] == LO_ON);
      dt_d[i] = (state_d[i] == DT_TO_HI) || (state_d[i] == DT_TO_LO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
      end
      ret_q         <= '0;
      pwm_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      dt_q          <= '0;
      fault_latched <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ret_q <= ret_d;
      pwm_q <= pwm_in;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dt_q  <= dt_d;
      if (fault)
        fault_latched <= 1'b1;
      else if (fault_clear)
        fault_latched <= 1'b0;
    end
  end

  assign gate.a_hi      = hi_q[0];
  assign gate.a_lo      = lo_q[0];
  assign gate.b_hi      = hi_q[1];
  assign gate.b_lo      = lo_q[1];
  assign gate.c_hi      = hi_q[2];
  assign gate.c_lo      = lo_q[2];
  assign gate.dt_active = dt_q;

endmodule

// File: tb/tb_deadtime_inserter_3phase.sv
// tb/tb_deadtime_inserter_3phase.sv - randomized bench with behavioural gate-drive model for deadtime_inserter_3phase
module tb_deadtime_inserter_3phase;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] dead_time;
  logic       fault;
  logic       fault_clear;
  logic       fault_latched;
  int         checks = 0;
  int         errors = 0;

  deadtime_inserter_3phase_if bus ();

  deadtime_inserter_3phase #(.DT_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .dead_time     (dead_time),
    .fault         (fault),
    .fault_clear   (fault_clear),
    .fault_latched (fault_latched),
    .gate          (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [5:0] gates();
    return {bus.c_lo, bus.c_hi, bus.b_lo, bus.b_hi, bus.a_lo, bus.a_hi};
  endfunction

  // Model: on_side 0=none 1=hi 2=lo; toward 0=none or side being waited for;
  // back = side to resume if the command reverses during the wait.
  int   on_side [3];
  int   toward  [3];
  int   left    [3];
  int   back    [3];
  bit   m_pq    [3];
  bit   m_flat;

  initial begin
    bit       s_rst, s_en, s_f, s_fc, ok;
    bit [2:0] s_pwm;
    int       s_dt, want, d;
    for (int p = 0; p < 3; p++) begin
      on_side[p] = 0; toward[p] = 0; left[p] = 0; back[p] = 0; m_pq[p] = 0;
    end
    m_flat = 0;
    forever begin
      @(posedge clk);
      s_rst = reset; s_en = enable; s_f = fault; s_fc = fault_clear;
      s_dt  = int'(dead_time);
      s_pwm = {bus.pwm_c, bus.pwm_b, bus.pwm_a};
      ok    = s_en && !s_f && !m_flat;
      if (s_rst) begin
        for (int p = 0; p < 3; p++) begin
          on_side[p] = 0; toward[p] = 0; left[p] = 0; back[p] = 0; m_pq[p] = 0;
        end
        m_flat = 0;
      end else begin
        d = (s_dt == 0) ? 1 : s_dt;
        for (int p = 0; p < 3; p++) begin
          want = m_pq[p] ? 1 : 2;
          if (!ok) begin
            on_side[p] = 0; toward[p] = 0; back[p] = 0;
          end else if (toward[p] != 0) begin
            if (want != toward[p]) begin
              if (back[p] == want) begin
                on_side[p] = want; toward[p] = 0; back[p] = 0;
              end else begin
                toward[p] = want; left[p] = d; back[p] = 0;
              end
            end else if (left[p] <= 1) begin
              on_side[p] = toward[p]; toward[p] = 0; back[p] = 0;
            end else begin
              left[p]--;
            end
          end else if (on_side[p] == 0) begin
            toward[p] = want; left[p] = d; back[p] = 0;
          end else if (on_side[p] != want) begin
            back[p] = on_side[p]; on_side[p] = 0; toward[p] = want; left[p] = d;
          end
        end
        for (int p = 0; p < 3; p++) m_pq[p] = s_pwm[p];
        if (s_f) m_flat = 1;
        else if (s_fc) m_flat = 0;
      end
      #1;
      chk("a_hi", 32'(bus.a_hi), 32'(on_side[0] == 1));
      chk("a_lo", 32'(bus.a_lo), 32'(on_side[0] == 2));
      chk("b_hi", 32'(bus.b_hi), 32'(on_side[1] == 1));
      chk("b_lo", 32'(bus.b_lo), 32'(on_side[1] == 2));
      chk("c_hi", 32'(bus.c_hi), 32'(on_side[2] == 1));
      chk("c_lo", 32'(bus.c_lo), 32'(on_side[2] == 2));
      chk("dt_active", 32'(bus.dt_active),
          32'({toward[2] != 0, toward[1] != 0, toward[0] != 0}));
      chk("fault_latched", 32'(fault_latched), 32'(m_flat));
      chk("shoot_through", 32'((bus.a_hi & bus.a_lo) | (bus.b_hi & bus.b_lo) | (bus.c_hi & bus.c_lo)), 32'd0);
    end
  end

  initial begin
    int offs, locnt;
    reset = 1'b1; enable = 1'b0; dead_time = 8'd4; fault = 1'b0; fault_clear = 1'b0;
    bus.pwm_a = 1'b0; bus.pwm_b = 1'b0; bus.pwm_c = 1'b0;
    tick(2);
    chk("reset_gates", 32'(gates()), 32'd0);
    chk("reset_dt", 32'(bus.dt_active), 32'd0);
    chk("reset_flat", 32'(fault_latched), 32'd0);
    reset = 1'b0;

    // Start-up: phase A commanded high, dead time 4
    bus.pwm_a = 1'b1;
    tick(1);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("start_a_hi_off", 32'(bus.a_hi), 32'd0);
      chk("start_dt0", 32'(bus.dt_active[0]), 32'd1);
    end
    tick(1);
    chk("start_a_hi_on", 32'(bus.a_hi), 32'd1);

    // Falling command: hi drops at k+1, lo rises at k+5
    bus.pwm_a = 1'b0;
    tick(1);
    chk("fall_k_hi", 32'(bus.a_hi), 32'd1);
    tick(1);
    chk("fall_k1_hi", 32'(bus.a_hi), 32'd0);
    tick(3);
    chk("fall_k4_lo", 32'(bus.a_lo), 32'd0);
    tick(1);
    chk("fall_k5_lo", 32'(bus.a_lo), 32'd1);

    // dead_time 0 acts as 1: one both-off cycle per transition
    dead_time = 8'd0;
    offs = 0;
    for (int t = 0; t < 8; t++) begin
      bus.pwm_b = ~bus.pwm_b;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        if (!bus.b_hi && !bus.b_lo) offs++;
      end
    end
    chk("dt0_off_cycles", 32'(offs), 32'd8);

    // Two-cycle low glitch on C inside a 5-cycle dead time
    dead_time = 8'd5;
    bus.pwm_c = 1'b1;
    tick(10);
    chk("glitch_pre_hi", 32'(bus.c_hi), 32'd1);
    bus.pwm_c = 1'b0;
    tick(2);
    bus.pwm_c = 1'b1;
    locnt = 0;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      if (bus.c_lo) locnt++;
    end
    chk("glitch_no_lo", 32'(locnt), 32'd0);
    chk("glitch_hi_back", 32'(bus.c_hi), 32'd1);

    // Fault latch, clear priority, restart with full dead time
    dead_time = 8'd4;
    fault = 1'b1;
    tick(1);
    fault = 1'b0;
    chk("fault_gates", 32'(gates()), 32'd0);
    chk("fault_latch", 32'(fault_latched), 32'd1);
    tick(3);
    fault = 1'b1; fault_clear = 1'b1;
    tick(1);
    fault = 1'b0; fault_clear = 1'b0;
    chk("fault_wins", 32'(fault_latched), 32'd1);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk("fault_cleared", 32'(fault_latched), 32'd0);
    tick(4);
    chk("restart_gates_off", 32'(gates()), 32'd0);
    tick(1);
    chk("restart_c_hi", 32'(bus.c_hi), 32'd1);
    chk("restart_a_lo", 32'(bus.a_lo), 32'd1);

    // dead_time change mid-interval applies to the next transition only
    dead_time = 8'd10;
    bus.pwm_a = 1'b1;
    tick(3);
    dead_time = 8'd2;
    tick(8);
    chk("dt10_k10_hi", 32'(bus.a_hi), 32'd0);
    tick(1);
    chk("dt10_k11_hi", 32'(bus.a_hi), 32'd1);
    bus.pwm_a = 1'b0;
    tick(3);
    chk("dt2_m2_lo", 32'(bus.a_lo), 32'd0);
    tick(1);
    chk("dt2_m3_lo", 32'(bus.a_lo), 32'd1);

    // enable dropped mid-dead-time
    bus.pwm_a = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(1);
    chk("dis_gates", 32'(gates()), 32'd0);
    chk("dis_dt", 32'(bus.dt_active), 32'd0);
    enable = 1'b1;

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom % 8 == 0) bus.pwm_a = ~bus.pwm_a;
      if ($urandom % 8 == 0) bus.pwm_b = ~bus.pwm_b;
      if ($urandom % 8 == 0) bus.pwm_c = ~bus.pwm_c;
      if ($urandom % 40 == 0) dead_time = 8'($urandom_range(0, 6));
      fault       = ($urandom % 150 == 0);
      fault_clear = ($urandom % 20 == 0);
      enable      = ($urandom % 80 != 0);
      reset       = ($urandom % 500 == 0);
    end
    reset = 1'b0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/deadtime_inserter_3phase.md
Name: deadtime_inserter_3phase

Overview:
- Sits directly downstream of the 3-phase PWM generator.
- Converts each single-ended phase command (pwm_a/b/c) into complementary high-side/low-side gate drives, with a programmable dead time so the two switches of a half-bridge are never on together.
- Provides a latched fault shutdown that forces every gate low until software clears it.

Parameters:
- DT_WIDTH, 8, width of the dead_time input and of the per-phase dead-time counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = gate drive allowed; 0 = all gates off
- dead_time  in  DT_WIDTH  both-off interval in clk cycles; 0 is treated as 1
- pwm_a  in  1  phase A command from PWM generator (1 = high side)
- pwm_b  in  1  phase B command
- pwm_c  in  1  phase C command
- fault  in  1  external fault (overcurrent/driver), same clock domain
- fault_clear  in  1  one-cycle request to clear the latched fault
- a_hi, a_lo  out  1 each  phase A high-side and low-side gate drives
- b_hi, b_lo  out  1 each  phase B gate drives
- c_hi, c_lo  out  1 each  phase C gate drives
- dt_active  out  3  bit0/1/2 = phase A/B/C is currently inside a dead-time interval
- fault_latched  out  1  sticky fault status

Behaviour:
- All outputs are registered. pwm_a/b/c are each registered once (pwm_q) before use.
- Reset (reset=1 at a clock edge):
  - all six gate outputs = 0, dt_active = 0, fault_latched = 0;
  - pwm_q = 0, counters = 0, every phase FSM = OFF.
- Per-phase FSM (three identical instances). States: OFF, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON.
  - OFF: hi=0, lo=0. When gating is allowed (enable=1 and fault_latched=0), go to DT_TO_HI if pwm_q=1, else DT_TO_LO.
  - DT_TO_HI / DT_TO_LO: hi=0, lo=0, dt_active bit=1. Lasts exactly D = max(dead_time,1) cycles. dead_time is captured on state entry; later changes apply only to the next transition. On expiry go to HI_ON / LO_ON respectively.
  - HI_ON: hi=1, lo=0. When pwm_q=0, go to DT_TO_LO.
  - LO_ON: hi=0, lo=1. When pwm_q=1, go to DT_TO_HI.
  - Glitch rule: in DT_TO_LO, if pwm_q returns to 1 before expiry, go directly back to HI_ON next cycle (the low side was never driven, so this is safe). DT_TO_HI mirrors this, returning to LO_ON.
- Latency:
  - An input edge at clock edge k is in pwm_q after edge k.
  - The off-going gate drops at edge k+1.
  - The on-going gate rises at edge k+1+D.
- Invariant: hi and lo of a phase are never both 1 in any cycle. After any on-to-on swap, both are 0 for at least D cycles.
- enable=0: the FSM goes to OFF and all gates are 0 from the next edge. Re-enable always passes through a dead-time state before any gate turns on.
- Fault handling:
  - fault=1 sampled at edge k: fault_latched=1 and all gates=0 at edge k; all FSMs go to OFF.
  - fault_latched clears only when fault_clear=1 and fault=0 in the same cycle. If fault and fault_clear are both 1, fault wins and stays latched.
  - After a clear, phases restart from OFF, i.e. with a full dead time.
- Reset asserted mid-operation (including mid-dead-time) behaves exactly as reset above on the next edge.
- The three phases are fully independent. Simultaneous transitions on multiple phases are each handled without interaction.

Test Plan:
- Reset, then enable=1, dead_time=4, pwm_a held 1 -> a_lo=0 throughout; a_hi=0 for 4 cycles with dt_active[0]=1, then a_hi=1.
- pwm_a 1->0 at edge k with dead_time=4 -> a_hi=0 at k+1; a_lo rises at k+5; never a_hi=a_lo=1.
- dead_time=0 and pwm_b toggling every 3 cycles -> exactly 1 both-off cycle at each transition.
- pwm_c low pulse of 2 cycles while in HI_ON with dead_time=5 -> c_lo never asserts; c_hi returns to 1 without reaching LO_ON.
- Fault pulse while running -> all gates 0 at the next edge, fault_latched=1. fault_clear while fault=1 -> still latched. fault_clear with fault=0 -> clears, then a full dead time before any gate rises.
- dead_time changed from 10 to 2 mid-interval -> current interval still 10 cycles, next interval 2. Also: enable dropped mid-dead-time -> all gates 0 and FSM in OFF.
